// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel plus the
// (pc, instr) channel toward decode.
interface instr_fetch_if #(
   parameter int WIDTH = 32
);
   // A transfer happens on a rising edge where valid && ready. A valid source
   // never waits for ready before asserting valid. The memory response has
   // no ready: it is always accepted.
   logic             imem_req_valid;
   logic             imem_req_ready;
   logic [WIDTH-1:0] imem_req_addr;
   logic             imem_rsp_valid;
   logic [WIDTH-1:0] imem_rsp_data;
   logic             if_valid;
   logic             if_ready;
   logic [WIDTH-1:0] if_pc;
   logic [WIDTH-1:0] if_instr;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, in-order memory requests, 2-entry (pc, instr) buffer
// toward decode, and redirect flush with discard of in-flight responses.
module instr_fetch #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   instr_fetch_if.master    bus
);
   logic [WIDTH-1:0] pc;
   logic             run;
   logic [1:0]       outstanding;
   logic [1:0]       drop;
   logic [WIDTH-1:0] aq [2];
   logic [1:0]       aq_cnt;
   logic [WIDTH-1:0] fq_pc [2];
   logic [WIDTH-1:0] fq_instr [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       fq_cnt;

   logic       pop;
   logic [2:0] used;
   logic       req_valid;
   logic       fire;
   logic       rsp;
   logic       keep;
   logic       discard;

   // Credits count both in-flight requests and buffered entries, so a
   // response always finds a free FIFO slot. run holds requests off until
   // the first edge after reset and drops them asynchronously on reset.
   assign pop       = (fq_cnt != 2'd0) && bus.if_ready;
   assign used      = {1'b0, outstanding} + {1'b0, fq_cnt} - {2'b00, pop};
   assign req_valid = run && !redirect && (used < 3'd2);
   assign fire      = req_valid && bus.imem_req_ready;
   assign rsp       = bus.imem_rsp_valid;
   assign keep      = rsp && (drop == 2'd0);
   assign discard   = rsp && (drop != 2'd0);

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc;
   assign bus.if_valid       = (fq_cnt != 2'd0);
   assign bus.if_pc          = fq_pc[rd_ptr];
   assign bus.if_instr       = fq_instr[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         run         <= 1'b0;
         outstanding <= 2'd0;
         drop        <= 2'd0;
         aq[0]       <= '0;
         aq[1]       <= '0;
         aq_cnt      <= 2'd0;
         fq_pc[0]    <= '0;
         fq_pc[1]    <= '0;
         fq_instr[0] <= '0;
         fq_instr[1] <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fq_cnt      <= 2'd0;
      end else begin
         run <= 1'b1;
         if (redirect) begin
            // Everything still outstanding after this edge belongs to the old path.
            pc          <= redirect_pc;
            outstanding <= outstanding - 2'(rsp);
            drop        <= outstanding - 2'(rsp);
            aq_cnt      <= 2'd0;
            fq_cnt      <= 2'd0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
         end else begin
            if (fire) pc <= pc + WIDTH'(4);
            outstanding <= outstanding + 2'(fire) - 2'(rsp);
            if (discard) drop <= drop - 2'd1;

            if (keep && fire) begin
               if (aq_cnt == 2'd1) begin
                  aq[0] <= pc;
               end else begin
                  aq[0] <= aq[1];
                  aq[1] <= pc;
               end
            end else if (keep) begin
               aq[0] <= aq[1];
            end else if (fire) begin
               aq[aq_cnt[0]] <= pc;
            end
            aq_cnt <= aq_cnt + 2'(fire) - 2'(keep);

            if (keep) begin
               fq_pc[wr_ptr]    <= aq[0];
               fq_instr[wr_ptr] <= bus.imem_rsp_data;
               wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fq_cnt <= fq_cnt + 2'(keep) - 2'(pop);
         end
      end
   end
endmodule
